// File: rtl/alu_job_queue_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_job_queue_pkg
//  Description : Shared ALU definitions: opcode constants, FSM state
//                encodings and small opcode-classification helpers. Shared
//                with the Sequential ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_job_queue_pkg;

    // Opcode field
    localparam int         c_OPC_W   = 4;
    localparam logic [3:0] c_OP_ADD  = 4'd0;
    localparam logic [3:0] c_OP_SUB  = 4'd1;
    localparam logic [3:0] c_OP_MUL  = 4'd2;
    localparam logic [3:0] c_OP_DIV  = 4'd3;

    // Engine FSM encodings
    localparam int c_STATE_W = 2;
    typedef logic [c_STATE_W-1:0] state_t;
    localparam state_t c_ST_IDLE = 2'd0;
    localparam state_t c_ST_LOAD = 2'd1;
    localparam state_t c_ST_EXEC = 2'd2;
    localparam state_t c_ST_DONE = 2'd3;

    // Opcodes 4..15 are illegal
    function automatic logic op_is_legal(input logic [c_OPC_W-1:0] op);
        return (op <= c_OP_DIV);
    endfunction

    // MUL and DIV iterate WIDTH times; everything else takes one EXEC cycle
    function automatic logic op_is_iterative(input logic [c_OPC_W-1:0] op);
        return (op == c_OP_MUL) || (op == c_OP_DIV);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_job_queue_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_job_queue_if
//  Description : Command / result bundle of the ALU job queue.
//                master : command producer and result consumer
//                slave  : the job queue itself
//  Signals     : cmd_valid/cmd_ready/cmd_opcode/cmd_in1/cmd_in2 (command),
//                res_valid/res_ready/res_high/res_low/res_flag/res_err
//                (result), busy, cmd_level (status)
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_job_queue_if #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) ();
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic [3:0]               cmd_opcode;
    logic [WIDTH-1:0]         cmd_in1;
    logic [WIDTH-1:0]         cmd_in2;
    logic                     res_valid;
    logic                     res_ready;
    logic [WIDTH-1:0]         res_high;
    logic [WIDTH-1:0]         res_low;
    logic                     res_flag;
    logic                     res_err;
    logic                     busy;
    logic [$clog2(DEPTH):0]   cmd_level;

    modport master (
        output cmd_valid, cmd_opcode, cmd_in1, cmd_in2, res_ready,
        input  cmd_ready, res_valid, res_high, res_low, res_flag, res_err,
               busy, cmd_level
    );

    modport slave (
        input  cmd_valid, cmd_opcode, cmd_in1, cmd_in2, res_ready,
        output cmd_ready, res_valid, res_high, res_low, res_flag, res_err,
               busy, cmd_level
    );
endinterface
`default_nettype wire

// File: rtl/alu_job_queue_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock FIFO with registered occupancy. The head entry
//                is presented combinationally on dout. Pushes when full and
//                pops when empty are ignored.
//  Ports       : clk, reset (sync, active-high), push/din, pop/dout,
//                full, empty, level (entries stored)
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH_DATA = 8,
    parameter int DEPTH      = 4
) (
    input  wire logic                    clk,
    input  wire logic                    reset,
    input  wire logic                    push,
    input  wire logic [WIDTH_DATA-1:0]   din,
    input  wire logic                    pop,
    output logic      [WIDTH_DATA-1:0]   dout,
    output logic                         full,
    output logic                         empty,
    output logic      [$clog2(DEPTH):0]  level
);
    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_LVL_W = c_PTR_W + 1;

    logic [WIDTH_DATA-1:0] r_mem [DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_LVL_W-1:0]    r_level;
    logic                  w_do_push;
    logic                  w_do_pop;

    assign full      = (r_level == c_LVL_W'(DEPTH));
    assign empty     = (r_level == '0);
    assign level     = r_level;
    assign dout      = r_mem[r_rd_ptr];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // Storage needs no reset: the pointers define what is valid
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/alu_job_queue.sv
`default_nettype none
// ============================================================================
//  Module      : alu_job_queue
//  Description : Queued multi-cycle ALU. Commands {opcode,in1,in2} are
//                buffered in a FIFO and executed one at a time by an
//                IDLE/LOAD/EXEC/DONE engine: ADD/SUB in one EXEC cycle,
//                MUL (shift-add) and DIV (restoring) in WIDTH EXEC cycles.
//  Ports       : clk, reset (sync, active-high),
//                bus (alu_job_queue_if.slave): command, result and status
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_job_queue
    import alu_job_queue_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  wire logic         clk,
    input  wire logic         reset,
    alu_job_queue_if.slave    bus
);
    localparam int c_LVL_W  = $clog2(DEPTH) + 1;
    localparam int c_DATA_W = c_OPC_W + 2 * WIDTH;
    localparam int c_CNT_W  = $clog2(WIDTH + 1);

    // FIFO side
    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic [c_DATA_W-1:0]  w_fifo_din;
    logic [c_DATA_W-1:0]  w_fifo_dout;
    logic [c_LVL_W-1:0]   w_level;

    // Engine
    state_t               r_state;
    state_t               w_state_next;
    logic [c_OPC_W-1:0]   r_op;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [2*WIDTH-1:0]   r_acc;        // shared MUL/DIV working register
    logic [c_CNT_W-1:0]   r_cnt;        // shared iteration counter
    logic                 r_flag;
    logic                 r_err;
    logic                 w_busy;
    logic                 w_res_valid;

    // Per-iteration datapath
    logic [2*WIDTH-1:0]   w_acc_exec;
    logic                 w_flag_exec;
    logic [WIDTH:0]       w_mul_sum;
    logic [WIDTH:0]       w_div_hi;
    logic [WIDTH:0]       w_div_diff;
    logic [WIDTH:0]       w_addsub;

    // ------------------------------------------------------------------
    // Command FIFO: ready comes from the registered level only, so a pop in
    // the same cycle never frees a slot early.
    // ------------------------------------------------------------------
    assign w_push     = bus.cmd_valid && !w_full;
    assign w_fifo_din = {bus.cmd_opcode, bus.cmd_in1, bus.cmd_in2};

    sync_fifo #(
        .WIDTH_DATA (c_DATA_W),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .din   (w_fifo_din),
        .pop   (w_pop),
        .dout  (w_fifo_dout),
        .full  (w_full),
        .empty (w_empty),
        .level (w_level)
    );

    assign bus.cmd_ready = !w_full;
    assign bus.cmd_level = w_level;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) r_state <= c_ST_IDLE;
        else       r_state <= w_state_next;
    end

    // FSM: next state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: if (!w_empty)                   w_state_next = c_ST_LOAD;
            c_ST_LOAD:                                 w_state_next = c_ST_EXEC;
            c_ST_EXEC: if (r_cnt == c_CNT_W'(1))       w_state_next = c_ST_DONE;
            c_ST_DONE: if (bus.res_ready)              w_state_next = c_ST_IDLE;
            default:                                   w_state_next = c_ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        w_pop       = 1'b0;
        w_busy      = 1'b1;
        w_res_valid = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                w_busy = 1'b0;
                w_pop  = !w_empty;
            end
            c_ST_DONE: w_res_valid = 1'b1;
            default:   ;
        endcase
    end

    assign bus.busy      = w_busy;
    assign bus.res_valid = w_res_valid;
    assign bus.res_high  = r_acc[2*WIDTH-1:WIDTH];
    assign bus.res_low   = r_acc[WIDTH-1:0];
    assign bus.res_flag  = r_flag;
    assign bus.res_err   = r_err;

    // ------------------------------------------------------------------
    // One EXEC step. r_acc is {high,low}:
    //   MUL: low holds the remaining multiplier bits, high the partial
    //        product; add the multiplicand when the LSB is set, shift right.
    //   DIV: shift {rem,quo} left, trial-subtract the divisor from the
    //        remainder, keep it and shift in 1 when non-negative. A zero
    //        divisor always "succeeds", which naturally yields
    //        quotient=all-ones and remainder=in1.
    // ------------------------------------------------------------------
    always_comb begin
        w_mul_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);
        w_div_hi    = r_acc[2*WIDTH-1:WIDTH-1];
        w_div_diff  = w_div_hi - {1'b0, r_b};
        w_addsub    = '0;
        w_acc_exec  = '0;
        w_flag_exec = 1'b0;
        case (r_op)
            c_OP_ADD: begin
                w_addsub    = {1'b0, r_a} + {1'b0, r_b};
                w_acc_exec  = {{WIDTH{1'b0}}, w_addsub[WIDTH-1:0]};
                w_flag_exec = w_addsub[WIDTH];
            end
            c_OP_SUB: begin
                w_addsub    = {1'b0, r_a} - {1'b0, r_b};
                w_acc_exec  = {{WIDTH{1'b0}}, w_addsub[WIDTH-1:0]};
                w_flag_exec = w_addsub[WIDTH];      // borrow == (in1 < in2)
            end
            c_OP_MUL: begin
                w_acc_exec  = {w_mul_sum, r_acc[WIDTH-1:1]};
                w_flag_exec = |w_mul_sum[WIDTH:1];  // final high word non-zero
            end
            c_OP_DIV: begin
                if (!w_div_diff[WIDTH]) begin
                    w_acc_exec = {w_div_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
                end else begin
                    w_acc_exec = {w_div_hi[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
                end
                w_flag_exec = (r_b == '0);
            end
            default: ;                              // illegal: all zero
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers. The job is captured at the pop edge because the
    // FIFO head moves on at that same edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op   <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_flag <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_pop) {r_op, r_a, r_b} <= w_fifo_dout;
                end
                c_ST_LOAD: begin
                    r_acc  <= {{WIDTH{1'b0}}, r_a};
                    r_cnt  <= op_is_iterative(r_op) ? c_CNT_W'(WIDTH) : c_CNT_W'(1);
                    r_err  <= !op_is_legal(r_op);
                    r_flag <= 1'b0;
                end
                c_ST_EXEC: begin
                    r_acc  <= w_acc_exec;
                    r_flag <= w_flag_exec;
                    if (r_cnt != c_CNT_W'(1)) r_cnt <= r_cnt - 1'b1;
                end
                default: ;                          // DONE holds results
            endcase
        end
    end
endmodule
`default_nettype wire
